// File: rtl/dvr_serializer_if.sv
// ----------------------------------------------------------------------------
// dvr_serializer_if
// Bundles the upstream (wide word) and downstream (narrow slice) valid/ready
// channels of the serializer.
//
// Parameters
//   IN_WIDTH  width of the upstream word
//   RATIO     slices per upstream word; OUT_WIDTH = IN_WIDTH / RATIO
//
// Signals
//   s_data  [IN_WIDTH]   upstream word
//   s_valid              upstream word valid
//   s_ready              serializer accepts upstream word
//   m_data  [OUT_WIDTH]  current slice to downstream
//   m_valid              slice valid
//   m_ready              downstream accepts slice
//   m_last               final slice of a word
//
// Modports
//   slave   serializer side (consumes words, produces slices)
//   master  environment side (produces words, consumes slices)
// ----------------------------------------------------------------------------
interface dvr_serializer_if #(
    parameter int unsigned IN_WIDTH = 128,
    parameter int unsigned RATIO    = 4
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH / RATIO;

    logic [IN_WIDTH-1:0]  s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last
    );
endinterface

// File: rtl/dvr_serializer.sv
// ----------------------------------------------------------------------------
// dvr_serializer
// Splits each IN_WIDTH upstream word into RATIO slices of OUT_WIDTH bits and
// sends them one per cycle downstream. A new word can be loaded in the same
// cycle the last slice of the previous word leaves, so streaming has no bubble.
//
// Parameters
//   IN_WIDTH  upstream word width (default 128)
//   RATIO     slices per word (default 4)
//
// Ports
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   dvr_serializer_if.slave: s_data/s_valid/s_ready upstream,
//         m_data/m_valid/m_ready/m_last downstream
//
// Build option
//   DVR_SER_MSB_FIRST_EN  when defined, slices leave most-significant first;
//                         otherwise least-significant first.
// ----------------------------------------------------------------------------
module dvr_serializer #(
    parameter int unsigned IN_WIDTH = 128,
    parameter int unsigned RATIO    = 4
) (
    input logic             clk,
    input logic             rst,
    dvr_serializer_if.slave bus
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH / RATIO;
    localparam int unsigned IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    typedef enum logic [0:0] {StEmpty, StBusy} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;

    logic [OUT_WIDTH-1:0] slices [RATIO];
    logic [IDX_W-1:0]     sel;
    logic                 at_last;
    logic                 m_valid;
    logic                 s_ready;
    logic                 in_xfer;
    logic                 out_xfer;

    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        assign slices[i] = word_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

`ifdef DVR_SER_MSB_FIRST_EN
    assign sel = IDX_LAST - idx_q;
`else
    assign sel = idx_q;
`endif

    assign at_last  = (idx_q == IDX_LAST);
    assign m_valid  = (state_q == StBusy);
    // Ready only looks at state, idx and m_ready, never at s_valid; rst forces
    // it low so nothing is accepted while reset is applied.
    assign s_ready  = !rst && ((state_q == StEmpty) || (bus.m_ready && at_last));
    assign in_xfer  = bus.s_valid && s_ready;
    assign out_xfer = m_valid && bus.m_ready;

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_valid && at_last;
    assign bus.m_data  = m_valid ? slices[sel] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    word_d  = bus.s_data;
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (out_xfer) begin
                    if (at_last) begin
                        idx_d = '0;
                        if (in_xfer) begin
                            word_d = bus.s_data;
                        end else begin
                            state_d = StEmpty;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StEmpty;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end
endmodule

// File: doc/dvr_serializer.md
DVR_SERIALIZER -- requirements
Module: dvr_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, width of the input stream word.
REQ-002 SHALL have parameter RATIO, default 4, number of output slices per input word; OUT_WIDTH = IN_WIDTH/RATIO is derived.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port s_data  input  IN_WIDTH  upstream word.
REQ-006 SHALL have port s_valid  input  1  upstream word valid.
REQ-007 SHALL have port s_ready  output  1  block accepts upstream word.
REQ-008 SHALL have port m_data  output  OUT_WIDTH  current slice to downstream.
REQ-009 SHALL have port m_valid  output  1  slice valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts slice.
REQ-011 SHALL have port m_last  output  1  high on the final slice of a word.

Function
REQ-012 SHALL transfer on a channel only in a cycle where valid and ready are both high.
REQ-013 SHALL use two states: EMPTY (no word held) and BUSY (word held, slice index idx in 0..RATIO-1).
REQ-014 SHALL, in EMPTY, drive s_ready=1, m_valid=0; on input transfer, capture s_data, set idx=0, go BUSY.
REQ-015 SHALL, in BUSY, drive m_valid=1, m_data=slice idx of the held word, m_last=(idx==RATIO-1).
REQ-016 SHALL, on output transfer with idx<RATIO-1, increment idx and stay BUSY.
REQ-017 SHALL, on output transfer with idx==RATIO-1, go EMPTY unless an input transfer occurs in the same cycle.
REQ-018 SHALL drive s_ready=1 in BUSY exactly when m_ready=1 and idx==RATIO-1; an input transfer then loads the new word, idx=0, stays BUSY (no bubble).
REQ-019 SHALL have 1-cycle latency from input transfer to first m_valid; sustained throughput one slice per cycle.
REQ-020 SHALL hold m_data, m_last and m_valid stable while m_valid=1 and m_ready=0.
REQ-021 SHALL not depend combinationally on s_valid for s_ready, nor on m_ready for m_valid.
REQ-022 SHALL, with RATIO=1, pass each word through as a single slice with m_last=1.
REQ-023 SHALL make idx exactly ceil(log2(RATIO)) bits wide (min 1) and never exceed RATIO-1.
REQ-024 SHALL drive m_data to zero while m_valid=0.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, enter EMPTY, idx=0, held word=0, m_valid=0, m_last=0, m_data=0.
REQ-026 SHALL drive s_ready=0 during any cycle rst=1.
REQ-027 SHALL discard a partially sent word when rst asserts mid-word; no remaining slices emitted after release.
REQ-028 SHALL accept a new word in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL use macro DVR_SER_MSB_FIRST_EN to select slice order.
REQ-030 SHALL, without DVR_SER_MSB_FIRST_EN, send slice idx = word[(idx+1)*OUT_WIDTH-1 : idx*OUT_WIDTH] (LSB slice first).
REQ-031 SHALL, with DVR_SER_MSB_FIRST_EN, send slice idx = word[(RATIO-idx)*OUT_WIDTH-1 : (RATIO-1-idx)*OUT_WIDTH] (MSB slice first).

Verification
REQ-032 SHALL verify: IN_WIDTH=32, RATIO=4, one word 0xDDCCBBAA, m_ready=1 -> m_data AA,BB,CC,DD on 4 consecutive cycles from cycle after accept, m_last only on DD.
REQ-033 SHALL verify: back-to-back words 0x03020100, 0x07060504, s_valid and m_ready held 1 -> 8 consecutive slices 00..07, no idle cycle, s_ready high only with slices 03 and 07.
REQ-034 SHALL verify: m_ready toggled 1,0,0,1,... during a word -> each slice held stable while stalled, no slice lost or duplicated, s_ready=0 until last slice transfers.
REQ-035 SHALL verify: rst pulsed 1 cycle after slice BB of 0xDDCCBBAA -> m_valid=0 next cycle, CC/DD never appear, next word 0x11223344 emits 44 first.
REQ-036 SHALL verify: DVR_SER_MSB_FIRST_EN defined, word 0xDDCCBBAA -> DD,CC,BB,AA with m_last on AA.
REQ-037 SHALL verify: RATIO=1, IN_WIDTH=8, words 0x5A,0xA5 streamed -> each output once with m_last=1, one word per cycle.
